// File: rtl/matrix_rotate_engine_pkg.sv
// Shared types and the quarter-turn helper for the Enigma matrix rotators.
package enigma_rot_pkg;

   localparam int PKG_BYTE_W = 8;
   localparam int MAT_BYTES  = 16;

   typedef logic [PKG_BYTE_W-1:0] byte_t;
   // Indexed as m[row][col], row-major with a0 at [0][0].
   typedef byte_t [3:0][3:0] matrix_t;

   typedef enum logic [1:0] {
      LOAD,
      ROTATE,
      DRAIN
   } rot_state_e;

   // One counter-clockwise quarter turn: out[r][c] = m[c][3-r].
   function automatic matrix_t quarter_ccw(input matrix_t m);
      matrix_t o;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            o[r][c] = m[c][3-r];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/matrix_rotate_engine_if.sv
// Byte-serial input/output handshake bundle of the matrix rotate engine.
// Carries out_chk only when ROTATE_CHECKSUM_EN is defined.
interface matrix_rotate_engine_if #(
   parameter int BYTE_W = 8
);

   logic              in_valid;
   logic              in_ready;
   logic [BYTE_W-1:0] in_byte;
   logic [1:0]        in_turns;
   logic              out_valid;
   logic              out_ready;
   logic [BYTE_W-1:0] out_byte;
   logic              out_last;
   logic              busy;
`ifdef ROTATE_CHECKSUM_EN
   logic [BYTE_W-1:0] out_chk;

   modport master (
      output in_valid, in_byte, in_turns, out_ready,
      input  in_ready, out_valid, out_byte, out_last, busy, out_chk
   );

   modport slave (
      input  in_valid, in_byte, in_turns, out_ready,
      output in_ready, out_valid, out_byte, out_last, busy, out_chk
   );
`else
   modport master (
      output in_valid, in_byte, in_turns, out_ready,
      input  in_ready, out_valid, out_byte, out_last, busy
   );

   modport slave (
      input  in_valid, in_byte, in_turns, out_ready,
      output in_ready, out_valid, out_byte, out_last, busy
   );
`endif

endinterface

// File: rtl/matrix_rotate_engine_quarter_turn.sv
// Combinational single counter-clockwise quarter turn of a 4x4 byte matrix.
module rot_quarter_turn
   import enigma_rot_pkg::*;
(
   input  matrix_t i_mat,
   output matrix_t o_mat
);

   assign o_mat = quarter_ccw(i_mat);

endmodule

// File: rtl/matrix_rotate_engine.sv
// Byte-serial 4x4 matrix rotator: load 16 bytes, apply 0-3 CCW turns, drain 16 bytes.
// Optional ROTATE_CHECKSUM_EN adds out_chk, the XOR of the block's input bytes.
module matrix_rotate_engine
   import enigma_rot_pkg::*;
#(
   parameter int BYTE_W = 8,
   parameter int DIM    = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   matrix_rotate_engine_if.slave bus
);

   localparam logic [3:0] LAST_IDX = 4'(DIM*DIM - 1);

   rot_state_e        r_state;
   rot_state_e        w_state_nxt;
   matrix_t           r_mat;
   matrix_t           w_mat_rot;
   logic [3:0]        r_idx;
   logic [1:0]        r_turns;
   logic              w_idx_last;
   logic              w_in_ready;
   logic              w_out_valid;
   logic              w_out_last;
   logic              w_busy;
   logic              w_in_fire;
   logic              w_out_fire;
   logic [BYTE_W-1:0] w_out_byte;

   rot_quarter_turn u_turn (
      .i_mat (r_mat),
      .o_mat (w_mat_rot)
   );

   assign w_idx_last = (r_idx == LAST_IDX);
   assign w_in_fire  = w_in_ready & bus.in_valid;
   assign w_out_fire = w_out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_out_last  = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         LOAD: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b0;
            if (bus.in_valid && w_idx_last) begin
               w_state_nxt = ROTATE;
            end
         end
         ROTATE: begin
            if (r_turns == 2'd0) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            w_out_valid = 1'b1;
            w_out_last  = w_idx_last;
            if (bus.out_ready && w_idx_last) begin
               w_state_nxt = LOAD;
            end
         end
         default: w_state_nxt = LOAD;
      endcase
   end

   // Storage, index and turn counter; a turn is applied only while the counter is nonzero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mat   <= '0;
         r_idx   <= '0;
         r_turns <= '0;
      end else begin
         if (w_in_fire) begin
            r_mat[r_idx[3:2]][r_idx[1:0]] <= bus.in_byte;
            if (r_idx == 4'd0) begin
               r_turns <= bus.in_turns;
            end
         end else if (r_state == ROTATE && r_turns != 2'd0) begin
            r_mat   <= w_mat_rot;
            r_turns <= r_turns - 2'd1;
         end
         if (w_in_fire || w_out_fire) begin
            r_idx <= w_idx_last ? 4'd0 : r_idx + 4'd1;
         end
      end
   end

   assign w_out_byte = (r_state == DRAIN) ? r_mat[r_idx[3:2]][r_idx[1:0]] : '0;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_byte  = w_out_byte;
   assign bus.out_last  = w_out_last;
   assign bus.busy      = w_busy;

`ifdef ROTATE_CHECKSUM_EN
   logic [BYTE_W-1:0] r_chk;

   // Restarts on the first byte of each block, so it holds steady through DRAIN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_chk <= '0;
      end else if (w_in_fire) begin
         r_chk <= (r_idx == 4'd0) ? bus.in_byte : (r_chk ^ bus.in_byte);
      end
   end

   assign bus.out_chk = r_chk;
`endif

endmodule

// File: tb/tb_matrix_rotate_engine.sv
// Table-driven scoreboard bench for matrix_rotate_engine.
module tb_matrix_rotate_engine;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   matrix_rotate_engine_if #(.BYTE_W(8)) bus ();

   matrix_rotate_engine #(.BYTE_W(8), .DIM(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]   turns;
      logic [127:0] din;
      logic [127:0] dout;
      logic         bp;
      logic [7:0]   chk;
   } vec_t;

   vec_t       vecs[6];
   vec_t       abort_vec;
   logic [7:0] sbq[$];
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [127:0] v, input int i);
      return v[127-8*i -: 8];
   endfunction

   task automatic drive_bytes(input logic [1:0] turns, input logic [127:0] din,
                              input logic [127:0] dout, input int n);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_byte  = byte_of(din, i);
         bus.in_turns = (i == 0) ? turns : ~turns;
         sbq.push_back(byte_of(dout, i));
         @(negedge clk);
         check("in_ready_load", bus.in_ready, 1);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_block(input vec_t v);
      int k;
      int first;
      int held;
      int n_out;
      drive_bytes(v.turns, v.din, v.dout, 16);
      k = 1;
      first = -1;
      held = 0;
      n_out = 0;
      while (sbq.size() != 0 && k < 300) begin
         if (v.bp) begin
            if (n_out == 6 && held < 5) begin
               bus.out_ready = 1'b0;
               held++;
            end else begin
               bus.out_ready = (k % 2 == 0);
            end
         end else begin
            bus.out_ready = 1'b1;
         end
         @(negedge clk);
         if (k == 1) check("in_ready_drop", bus.in_ready, 0);
         if (bus.out_valid === 1'b1) begin
            if (first < 0) begin
               first = k;
               check("latency", k, v.turns + 2);
            end
            check("in_ready_drain", bus.in_ready, 0);
            check("out_byte", bus.out_byte, sbq[0]);
            check("out_last", bus.out_last, (n_out == 15));
`ifdef ROTATE_CHECKSUM_EN
            check("out_chk", bus.out_chk, v.chk);
`endif
            if (bus.out_ready) begin
               void'(sbq.pop_front());
               n_out++;
            end
         end
         @(posedge clk);
         #1;
         k++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d bytes_left required=0", sbq.size());
         sbq.delete();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("busy_after", bus.busy, 0);
      check("in_ready_after", bus.in_ready, 1);
      check("out_valid_after", bus.out_valid, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"}, bus.in_ready, 1);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_last"}, bus.out_last, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_out_byte"}, bus.out_byte, 0);
`ifdef ROTATE_CHECKSUM_EN
      check({tag, "_out_chk"}, bus.out_chk, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      vecs[0] = '{2'd0, 128'h000102030405060708090A0B0C0D0E0F,
                        128'h000102030405060708090A0B0C0D0E0F, 1'b0, 8'h00};
      vecs[1] = '{2'd1, 128'h000102030405060708090A0B0C0D0E0F,
                        128'h03070B0F02060A0E0105090D0004080C, 1'b0, 8'h00};
      vecs[2] = '{2'd2, 128'h000102030405060708090A0B0C0D0E0F,
                        128'h0F0E0D0C0B0A09080706050403020100, 1'b0, 8'h00};
      vecs[3] = '{2'd3, 128'h000102030405060708090A0B0C0D0E0F,
                        128'h0C0804000D0905010E0A06020F0B0703, 1'b0, 8'h00};
      vecs[4] = '{2'd1, 128'h000102030405060708090A0B0C0D0E0F,
                        128'h03070B0F02060A0E0105090D0004080C, 1'b1, 8'h00};
      vecs[5] = '{2'd0, 128'h01000000000000000000000000000000,
                        128'h01000000000000000000000000000000, 1'b0, 8'h01};
      abort_vec = '{2'd2, 128'h101112131415161718191A1B1C1D1E1F,
                          128'h1F1E1D1C1B1A19181716151413121110, 1'b0, 8'h00};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_byte   = '0;
      bus.in_turns  = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         run_block(vecs[v]);
      end

      // Abort a partially loaded block, then confirm a clean block follows.
      drive_bytes(2'd1, vecs[1].din, vecs[1].dout, 9);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sbq.delete();
      @(negedge clk);
      check_reset_values("abort");
      @(posedge clk);
      #1;
      run_block(abort_vec);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
